ppl_regd_skid: RTL and testbench

- IF/ID pipeline register.
- Sits directly downstream of the fetch PC register.
- Captures PC, PC+4 and instruction word each advancing cycle; inserts bubbles on flush; flags misaligned fetch addresses.
- One-entry skid buffer keeps the instruction word, which is valid only in its fetch cycle, safe across decode stalls.

---
 rtl/ppl_regd_skid.sv | 169 ++++++++++++++++
 tb/tb_ppl_regd_skid.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ppl_regd_skid.sv
// ============================================================================
// Module   : ppl_regd_skid
// Purpose  : IF/ID pipeline register with one-entry skid buffer for stalls.
//            Optional perf counters: define PPL_REGD_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ppl_regd_skid #(
    parameter logic [31:0] NOP_INST = 32'h00000000,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcIn,
    input  logic [31:0] instIn,
    input  logic        validIn,
    input  logic        pcContinue,
    input  logic        flush,
    output logic [31:0] pcOut,
    output logic [31:0] pcPlus4Out,
    output logic [31:0] instOut,
    output logic        validOut,
    output logic        misalignOut,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;

    logic [31:0] src_pc;
    logic [31:0] src_inst;
    logic        src_valid;
    logic        src_misalign;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_RUN;
        end else if (!pcContinue) begin
            if (state_q == ST_RUN && validIn) begin
                state_d = ST_HOLD;
            end
        end else begin
            state_d = ST_RUN;
        end
    end

    // Leaving HOLD replays the buffered word: instIn is stale by then.
    always_comb begin
        src_pc       = (state_q == ST_HOLD) ? hold_pc_q   : pcIn;
        src_inst     = (state_q == ST_HOLD) ? hold_inst_q : instIn;
        src_valid    = (state_q == ST_HOLD) ? 1'b1        : validIn;
        src_misalign = src_valid && (src_pc[1:0] != 2'b00);
    end

    // Datapath / output logic
    always_comb begin
        pc_d        = pc_q;
        pc_plus4_d  = pc_plus4_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        misalign_d  = misalign_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        if (flush) begin
            pc_d        = pcIn;
            pc_plus4_d  = pcIn + 32'd4;
            inst_d      = NOP_INST;
            valid_d     = 1'b0;
            misalign_d  = 1'b0;
            hold_pc_d   = 32'h00000000;
            hold_inst_d = 32'h00000000;
        end else if (!pcContinue) begin
            if (state_q == ST_RUN && validIn) begin
                hold_pc_d   = pcIn;
                hold_inst_d = instIn;
            end
        end else begin
            pc_d       = src_pc;
            pc_plus4_d = src_pc + 32'd4;
            valid_d    = src_valid;
            misalign_d = src_misalign;
            inst_d     = (src_valid && !src_misalign) ? src_inst : NOP_INST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            pc_plus4_q  <= RESET_PC + 32'd4;
            inst_q      <= NOP_INST;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
            hold_pc_q   <= 32'h00000000;
            hold_inst_q <= 32'h00000000;
        end else begin
            pc_q        <= pc_d;
            pc_plus4_q  <= pc_plus4_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
            misalign_q  <= misalign_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    assign pcOut       = pc_q;
    assign pcPlus4Out  = pc_plus4_q;
    assign instOut     = inst_q;
    assign validOut    = valid_q;
    assign misalignOut = misalign_q;

`ifdef PPL_REGD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pcContinue && !flush && stall_cnt_q != 32'hFFFFFFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && flush_cnt_q != 32'hFFFFFFFF) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'h00000000;
            flush_cnt_q <= 32'h00000000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;
`else
    assign stallCount = 32'h00000000;
    assign flushCount = 32'h00000000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ppl_regd_skid.sv
// Testbench for ppl_regd_skid: vector table driven through a scoreboard queue,
// plus hand-written async-reset-during-stall sequence.
`default_nettype none

module tb_ppl_regd_skid;

    logic        clk;
    logic        reset;
    logic [31:0] pcIn, instIn;
    logic        validIn, pcContinue, flush;
    logic [31:0] pcOut, pcPlus4Out, instOut;
    logic        validOut, misalignOut;
    logic [31:0] stallCount, flushCount;

    ppl_regd_skid dut (
        .clk        (clk),
        .reset      (reset),
        .pcIn       (pcIn),
        .instIn     (instIn),
        .validIn    (validIn),
        .pcContinue (pcContinue),
        .flush      (flush),
        .pcOut      (pcOut),
        .pcPlus4Out (pcPlus4Out),
        .instOut    (instOut),
        .validOut   (validOut),
        .misalignOut(misalignOut),
        .stallCount (stallCount),
        .flushCount (flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        vin;
        logic        cont;
        logic        fl;
        logic [31:0] epc;
        logic [31:0] ep4;
        logic [31:0] einst;
        logic        ev;
        logic        em;
    } vec_t;

    typedef struct {
        logic [31:0] epc;
        logic [31:0] ep4;
        logic [31:0] einst;
        logic        ev;
        logic        em;
        logic [31:0] estall;
        logic [31:0] eflush;
    } exp_t;

    localparam int NV = 17;
    vec_t vecs[NV];
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int perf_en;
    logic [31:0] exp_stall, exp_flush;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [31:0] p, input logic [31:0] i,
                                input logic v, input logic c, input logic f,
                                input logic [31:0] epc, input logic [31:0] ep4,
                                input logic [31:0] ei, input logic ev, input logic em);
        vec_t t;
        t.rst = r; t.pc = p; t.inst = i; t.vin = v; t.cont = c; t.fl = f;
        t.epc = epc; t.ep4 = ep4; t.einst = ei; t.ev = ev; t.em = em;
        return t;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".pcOut"},       pcOut,              e.epc);
        chk({tag, ".pcPlus4Out"},  pcPlus4Out,         e.ep4);
        chk({tag, ".instOut"},     instOut,            e.einst);
        chk({tag, ".validOut"},    {31'd0, validOut},  {31'd0, e.ev});
        chk({tag, ".misalignOut"}, {31'd0, misalignOut}, {31'd0, e.em});
        chk({tag, ".stallCount"},  stallCount,         e.estall);
        chk({tag, ".flushCount"},  flushCount,         e.eflush);
    endtask

    task automatic drive(input logic r, input logic [31:0] p, input logic [31:0] i,
                         input logic v, input logic c, input logic f);
        reset = r; pcIn = p; instIn = i; validIn = v; pcContinue = c; flush = f;
    endtask

    // Counter expectations follow the events applied, not the DUT.
    task automatic count_edge(input logic r, input logic c, input logic f);
        if (r) begin
            exp_stall = 0; exp_flush = 0;
        end else if (perf_en != 0) begin
            if (!c && !f) exp_stall = exp_stall + 1;
            if (f)        exp_flush = exp_flush + 1;
        end
    endtask

    initial begin
        exp_t e;
`ifdef PPL_REGD_PERF_EN
        perf_en = 1;
`else
        perf_en = 0;
`endif
        exp_stall = 0;
        exp_flush = 0;

        //            rst pc            inst          v  c  f   pcOut         pcPlus4       instOut       v  m
        vecs[0]  = mk(1, 32'h00000000, 32'h00000000, 0, 0, 0, 32'h00000000, 32'h00000004, 32'h00000000, 0, 0);
        vecs[1]  = mk(0, 32'h00400000, 32'h20080005, 1, 1, 0, 32'h00400000, 32'h00400004, 32'h20080005, 1, 0);
        vecs[2]  = mk(0, 32'h00000100, 32'hAAAA0001, 1, 0, 0, 32'h00400000, 32'h00400004, 32'h20080005, 1, 0);
        vecs[3]  = mk(0, 32'h00000100, 32'hDEADBEEF, 1, 0, 0, 32'h00400000, 32'h00400004, 32'h20080005, 1, 0);
        vecs[4]  = mk(0, 32'h00000100, 32'hDEADBEEF, 1, 0, 0, 32'h00400000, 32'h00400004, 32'h20080005, 1, 0);
        vecs[5]  = mk(0, 32'h00000100, 32'hDEADBEEF, 1, 1, 0, 32'h00000100, 32'h00000104, 32'hAAAA0001, 1, 0);
        vecs[6]  = mk(0, 32'h00000104, 32'h11111111, 1, 0, 0, 32'h00000100, 32'h00000104, 32'hAAAA0001, 1, 0);
        vecs[7]  = mk(0, 32'h00000104, 32'h33333333, 1, 0, 1, 32'h00000104, 32'h00000108, 32'h00000000, 0, 0);
        vecs[8]  = mk(0, 32'h00000108, 32'h22222222, 1, 1, 0, 32'h00000108, 32'h0000010C, 32'h22222222, 1, 0);
        vecs[9]  = mk(0, 32'h00400002, 32'h12345678, 1, 1, 0, 32'h00400002, 32'h00400006, 32'h00000000, 1, 1);
        vecs[10] = mk(0, 32'hFFFFFFFC, 32'h0BADF00D, 1, 1, 0, 32'hFFFFFFFC, 32'h00000000, 32'h0BADF00D, 1, 0);
        vecs[11] = mk(0, 32'h00000200, 32'h55555555, 0, 1, 0, 32'h00000200, 32'h00000204, 32'h00000000, 0, 0);
        vecs[12] = mk(0, 32'h00000200, 32'h55555555, 0, 0, 0, 32'h00000200, 32'h00000204, 32'h00000000, 0, 0);
        vecs[13] = mk(0, 32'h00000204, 32'h66666666, 1, 1, 0, 32'h00000204, 32'h00000208, 32'h66666666, 1, 0);
        vecs[14] = mk(0, 32'h00000301, 32'h77777777, 1, 0, 0, 32'h00000204, 32'h00000208, 32'h66666666, 1, 0);
        vecs[15] = mk(0, 32'h00000301, 32'h88888888, 1, 1, 0, 32'h00000301, 32'h00000305, 32'h00000000, 1, 1);
        vecs[16] = mk(0, 32'h00000400, 32'h99999999, 1, 1, 1, 32'h00000400, 32'h00000404, 32'h00000000, 0, 0);

        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);

        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].rst, vecs[k].pc, vecs[k].inst, vecs[k].vin, vecs[k].cont, vecs[k].fl);
            count_edge(vecs[k].rst, vecs[k].cont, vecs[k].fl);
            e.epc = vecs[k].epc; e.ep4 = vecs[k].ep4; e.einst = vecs[k].einst;
            e.ev = vecs[k].ev; e.em = vecs[k].em;
            e.estall = exp_stall; e.eflush = exp_flush;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_outputs($sformatf("vec%0d", k), e);
            @(negedge clk);
        end

        // Reset mid-stall: asynchronous reset clears everything, buffer included.
        drive(1, 32'h0, 32'h0, 0, 0, 0);
        #1;
        count_edge(1, 0, 0);
        chk("async_rst0.pcOut", pcOut, 32'h00000000);
        chk("async_rst0.stallCount", stallCount, 32'h00000000);
        @(negedge clk);
        drive(0, 32'h000004FC, 32'h00000001, 1, 1, 0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            drive(0, 32'h00000500, (k == 0) ? 32'hCAFEBABE : 32'h0000FFFF, 1, 0, 0);
            count_edge(0, 0, 0);
            @(negedge clk);
        end
        chk("pre_rst.stallCount", stallCount, (perf_en != 0) ? 32'd4 : 32'd0);
        chk("pre_rst.instOut", instOut, 32'h00000001);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst.pcOut", pcOut, 32'h00000000);
        chk("mid_rst.pcPlus4Out", pcPlus4Out, 32'h00000004);
        chk("mid_rst.validOut", {31'd0, validOut}, 32'd0);
        chk("mid_rst.instOut", instOut, 32'h00000000);
        chk("mid_rst.stallCount", stallCount, 32'h00000000);
        @(negedge clk);
        drive(0, 32'h00000600, 32'h0F0F0F0F, 1, 1, 0);
        @(posedge clk);
        #1;
        chk("post_rst.instOut", instOut, 32'h0F0F0F0F);
        chk("post_rst.pcOut", pcOut, 32'h00000600);
        chk("post_rst.validOut", {31'd0, validOut}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
